game_display_box_controller: RTL and testbench
==============================================

# game_display_box_controller

Sequences the on-screen game display box: it accepts target rectangle commands, validates them and animates the four corner coordinates toward the target by a fixed pixel step once per video frame. Its outputs `display_x0/y0/x1/y1` drive the border renderer directly. Coordinates change only on frame boundaries, so the box never tears mid-frame.

## Interface
- `SCREEN_W`, default 640: active width in pixels.
- `SCREEN_H`, default 480: active height in pixels.
- `BORDER`, default 5: border thickness; sets the legal coordinate margin.
- `STEP`, default 4: maximum pixels each coordinate moves per frame; legal range 1..255.
- `INIT_X0` / `INIT_Y0` / `INIT_X1` / `INIT_Y1`, defaults 220 / 240 / 420 / 400: reset rectangle.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per frame, at vertical blank start.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1` in 10 each: target rectangle, inclusive.
- `cmd_instant` in 1: snap to the target on the next frame instead of stepping.
- `display_x0`, `display_y0`, `display_x1`, `display_y1` out 10 each: current rectangle.
- `busy` out 1: high while a move is pending.
- `done` out 1: one-cycle pulse when the rectangle reaches its target.
- `cmd_err` out 1: one-cycle pulse when a command is rejected.

## Operation
- States: IDLE and MOVE. `cmd_ready = (state == IDLE)`. `busy = (state == MOVE)`.
- Command validation happens in the acceptance cycle. A command is legal when all of these hold:
  - `x0 < x1` and `y0 < y1`
  - `x0 >= BORDER` and `y0 >= BORDER`
  - `x1 <= SCREEN_W-1-BORDER` and `y1 <= SCREEN_H-1-BORDER`
- An illegal command is still consumed by the handshake. The block pulses `cmd_err` the next cycle, stays in IDLE, and leaves the coordinates unchanged.
- A legal command latches the target and the instant flag, then goes to MOVE.
- In MOVE, on each `frame_tick`:
  - Stepping: each coordinate independently moves toward its target by `min(STEP, |target - current|)`. All four coordinates update on the same edge.
  - Instant: all four coordinates load the target.
- When every coordinate equals its target after an update, the same edge sets state to IDLE and `done = 1` for one cycle.
- A command equal to the current rectangle still enters MOVE. It completes on the next `frame_tick` with no coordinate change, and `done` pulses.
- Arithmetic: differences are computed in 11-bit signed; the step is zero-extended to 11 bits. No overflow is possible because targets are range-checked.
- `frame_tick` outside MOVE is ignored.
- `cmd_valid` during MOVE is not accepted (`cmd_ready = 0`). Command inputs are don't-care while not accepted.
- Reset, whether idle or mid-move:
  - coordinates load INIT_*
  - state goes to IDLE
  - `busy`, `done`, `cmd_err` = 0
  - `cmd_ready` = 1 after the reset edge
  - the pending target is discarded.

## Timing
- Acceptance at edge t puts the block in MOVE at t+1. A `frame_tick` in the acceptance cycle itself is ignored; the first update occurs on the first `frame_tick` at cycle ≥ t+1.
- The coordinates are registered and change only on the edge that samples `frame_tick` in MOVE, or on reset.
- `done` and `cmd_ready` rise together, on the edge after the final `frame_tick` sample. A new command can be accepted in that same cycle.
- `cmd_err` is registered one cycle after the handshake. A back-to-back command is accepted the next cycle.
- A move of maximum distance D pixels takes ceil(D/STEP) frames. Instant moves take 1 frame.

## Structure
- Shared package `game_display_pkg`: `SCREEN_W`, `SCREEN_H`, `BORDER`, coordinate width `COORD_W = 10`, state encoding.
- Sub-module `game_display_axis_stepper`: combinational next value for one coordinate, computed from (current, target, STEP, instant). It is instantiated 4×. The top level holds the FSM, the target registers and the validation logic.

## Test plan
- Step move (STEP=4): reset, then cmd (200,240,440,400) → `busy` for 5 ticks; x0 goes 216, 212, 208, 204, 200 and x1 goes 424…440; y unchanged; `done` pulses once after tick 5.
- Uneven remainder: cmd x0=210, other coordinates unchanged from reset → x0 goes 216, 212, 210 over 3 ticks; `done` after tick 3.
- Illegal: cmd (300,240,300,400), then cmd (2,240,420,400) → `cmd_err` pulse for each; coordinates remain at INIT; `cmd_ready` stays 1.
- Instant: cmd (100,100,540,380) with `cmd_instant=1` → no change before the next tick; all four coordinates load on that tick; `done` pulses; total 1 frame.
- Backpressure: hold `cmd_valid` with a second target during a move → `cmd_ready` is 0 until `done`; the second command is accepted in the `done` cycle and executes afterward.
- Reset mid-move: assert `rst_n=0` when x0=208 → the next edge restores (220,240,420,400) with `busy=0`; a subsequent `frame_tick` causes no change.

Source files
------------

// File: rtl/game_display_pkg.sv
// Shared screen geometry, coordinate width and
// FSM state encoding for the display box controller.
package game_display_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BORDER   = 5;
  localparam int COORD_W  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

endpackage

// File: rtl/game_display_axis_stepper.sv
// Next value for one box coordinate: moves toward
// the target by at most STEP, or snaps when instant.
module game_display_axis_stepper
  import game_display_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [COORD_W-1:0] cur,
  input  logic [COORD_W-1:0] tgt,
  input  logic               instant,
  output logic [COORD_W-1:0] nxt
);

  localparam logic [7:0] STEP8 = 8'(STEP);

  logic signed [10:0] diff;
  logic signed [10:0] step;
  logic [COORD_W-1:0] step_c;

  assign diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign step   = $signed({3'b000, STEP8});
  assign step_c = {2'b00, STEP8};

  // Clamp the move to the remaining distance
  always_comb begin
    nxt = tgt;
    if (!instant) begin
      if (diff > step)
        nxt = cur + step_c;
      else if (diff < -step)
        nxt = cur - step_c;
    end
  end

endmodule

// File: rtl/game_display_box_controller.sv
// Accepts and validates box target commands and animates
// the four corners toward the target once per frame.
module game_display_box_controller
  import game_display_pkg::*;
#(
  parameter int SCREEN_W = game_display_pkg::SCREEN_W,
  parameter int SCREEN_H = game_display_pkg::SCREEN_H,
  parameter int BORDER   = game_display_pkg::BORDER,
  parameter int STEP     = 4,
  parameter int INIT_X0  = 220,
  parameter int INIT_Y0  = 240,
  parameter int INIT_X1  = 420,
  parameter int INIT_Y1  = 400
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               cmd_instant,
  output logic [COORD_W-1:0] display_x0,
  output logic [COORD_W-1:0] display_y0,
  output logic [COORD_W-1:0] display_x1,
  output logic [COORD_W-1:0] display_y1,
  output logic               busy,
  output logic               done,
  output logic               cmd_err
);

  localparam logic [COORD_W-1:0] LO   = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] HI_X = COORD_W'(SCREEN_W - 1 - BORDER);
  localparam logic [COORD_W-1:0] HI_Y = COORD_W'(SCREEN_H - 1 - BORDER);

  state_t             state;
  logic [COORD_W-1:0] tx0, ty0, tx1, ty1;
  logic               inst;
  logic [COORD_W-1:0] nx0, ny0, nx1, ny1;
  logic               legal;
  logic               arrive;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == MOVE);

  assign legal = (cmd_x0 < cmd_x1) && (cmd_y0 < cmd_y1)
              && (cmd_x0 >= LO) && (cmd_y0 >= LO)
              && (cmd_x1 <= HI_X) && (cmd_y1 <= HI_Y);

  assign arrive = (nx0 == tx0) && (ny0 == ty0)
               && (nx1 == tx1) && (ny1 == ty1);

  game_display_axis_stepper #(.STEP(STEP)) u_x0 (
    .cur(display_x0), .tgt(tx0), .instant(inst), .nxt(nx0));
  game_display_axis_stepper #(.STEP(STEP)) u_y0 (
    .cur(display_y0), .tgt(ty0), .instant(inst), .nxt(ny0));
  game_display_axis_stepper #(.STEP(STEP)) u_x1 (
    .cur(display_x1), .tgt(tx1), .instant(inst), .nxt(nx1));
  game_display_axis_stepper #(.STEP(STEP)) u_y1 (
    .cur(display_y1), .tgt(ty1), .instant(inst), .nxt(ny1));

  // Command FSM, target latch and frame-locked coordinate update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      display_x0 <= COORD_W'(INIT_X0);
      display_y0 <= COORD_W'(INIT_Y0);
      display_x1 <= COORD_W'(INIT_X1);
      display_y1 <= COORD_W'(INIT_Y1);
      tx0        <= '0;
      ty0        <= '0;
      tx1        <= '0;
      ty1        <= '0;
      inst       <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (legal) begin
              tx0   <= cmd_x0;
              ty0   <= cmd_y0;
              tx1   <= cmd_x1;
              ty1   <= cmd_y1;
              inst  <= cmd_instant;
              state <= MOVE;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        MOVE: begin
          if (frame_tick) begin
            display_x0 <= nx0;
            display_y0 <= ny0;
            display_x1 <= nx1;
            display_y1 <= ny1;
            if (arrive) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_display_box_controller.sv
// Directed bench for the display box controller:
// stepping, remainders, rejects, instant, backpressure, reset.
module tb_game_display_box_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic       cmd_instant = 1'b0;
  logic [9:0] display_x0, display_y0, display_x1, display_y1;
  logic       busy, done, cmd_err;

  int n_vec = 0;
  int n_err = 0;

  int ex0[5] = '{216, 212, 208, 204, 200};
  int ex1[5] = '{424, 428, 432, 436, 440};
  int ux0[3] = '{216, 212, 210};

  game_display_box_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_instant(cmd_instant),
    .display_x0(display_x0), .display_y0(display_y0),
    .display_x1(display_x1), .display_y1(display_y1),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rect(input string tag, input int a, input int b,
                          input int c, input int d);
    chk({tag, ".x0"}, {6'd0, display_x0}, 16'(a));
    chk({tag, ".y0"}, {6'd0, display_y0}, 16'(b));
    chk({tag, ".x1"}, {6'd0, display_x1}, 16'(c));
    chk({tag, ".y1"}, {6'd0, display_y1}, 16'(d));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    frame_tick = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_cmd(input int a, input int b, input int c,
                         input int d, input logic ins);
    cmd_valid = 1'b1;
    cmd_x0 = 10'(a);
    cmd_y0 = 10'(b);
    cmd_x1 = 10'(c);
    cmd_y1 = 10'(d);
    cmd_instant = ins;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk_rect("rst", 220, 240, 420, 400);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    chk("rst.done", {15'd0, done}, 16'd0);
    chk("rst.err", {15'd0, cmd_err}, 16'd0);
    chk("rst.ready", {15'd0, cmd_ready}, 16'd1);

    // step move; frame_tick in acceptance cycle is ignored
    set_cmd(200, 240, 440, 400, 1'b0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    cmd_valid = 1'b0;
    chk("step.busy", {15'd0, busy}, 16'd1);
    chk("step.ready", {15'd0, cmd_ready}, 16'd0);
    chk_rect("step.acc", 220, 240, 420, 400);
    tick();
    chk_rect("step.notick", 220, 240, 420, 400);
    for (int i = 0; i < 5; i++) begin
      frame();
      chk_rect($sformatf("step.t%0d", i + 1), ex0[i], 240, ex1[i], 400);
      chk($sformatf("step.done%0d", i + 1), {15'd0, done},
          16'(i == 4));
      chk($sformatf("step.busy%0d", i + 1), {15'd0, busy},
          16'(i != 4));
    end
    tick();
    chk("step.done_pulse", {15'd0, done}, 16'd0);

    // uneven remainder
    do_reset();
    set_cmd(210, 240, 420, 400, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame();
      chk_rect($sformatf("unev.t%0d", i + 1), ux0[i], 240, 420, 400);
      chk($sformatf("unev.done%0d", i + 1), {15'd0, done},
          16'(i == 2));
    end

    // illegal commands, back to back
    do_reset();
    set_cmd(300, 240, 300, 400, 1'b0);
    tick();
    chk("ill1.err", {15'd0, cmd_err}, 16'd1);
    chk("ill1.ready", {15'd0, cmd_ready}, 16'd1);
    set_cmd(2, 240, 420, 400, 1'b0);
    tick();
    chk("ill2.err", {15'd0, cmd_err}, 16'd1);
    chk("ill2.ready", {15'd0, cmd_ready}, 16'd1);
    cmd_valid = 1'b0;
    tick();
    chk("ill.err_clr", {15'd0, cmd_err}, 16'd0);
    chk("ill.busy", {15'd0, busy}, 16'd0);
    chk_rect("ill", 220, 240, 420, 400);

    // right/bottom limit violation
    set_cmd(220, 240, 635, 400, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("ill3.err", {15'd0, cmd_err}, 16'd1);
    set_cmd(220, 240, 634, 474, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("edge.err", {15'd0, cmd_err}, 16'd0);
    chk("edge.busy", {15'd0, busy}, 16'd1);
    do_reset();

    // command equal to current rectangle
    set_cmd(220, 240, 420, 400, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("same.busy", {15'd0, busy}, 16'd1);
    frame();
    chk("same.done", {15'd0, done}, 16'd1);
    chk_rect("same", 220, 240, 420, 400);

    // instant
    set_cmd(100, 100, 540, 380, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk_rect("inst.pre", 220, 240, 420, 400);
    frame();
    chk_rect("inst.t1", 100, 100, 540, 380);
    chk("inst.done", {15'd0, done}, 16'd1);
    chk("inst.busy", {15'd0, busy}, 16'd0);

    // backpressure: second command held during a move
    set_cmd(100, 100, 548, 380, 1'b0);
    tick();
    set_cmd(100, 100, 540, 380, 1'b0);
    tick();
    chk("bp.ready0", {15'd0, cmd_ready}, 16'd0);
    frame();
    chk("bp.ready1", {15'd0, cmd_ready}, 16'd0);
    chk("bp.x1a", {6'd0, display_x1}, 16'd544);
    frame();
    chk("bp.x1b", {6'd0, display_x1}, 16'd548);
    chk("bp.done", {15'd0, done}, 16'd1);
    chk("bp.ready2", {15'd0, cmd_ready}, 16'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp.acc2", {15'd0, busy}, 16'd1);
    frame();
    chk("bp.x1c", {6'd0, display_x1}, 16'd544);
    frame();
    chk("bp.x1d", {6'd0, display_x1}, 16'd540);
    chk("bp.done2", {15'd0, done}, 16'd1);

    // reset mid-move
    do_reset();
    set_cmd(200, 240, 440, 400, 1'b0);
    tick();
    cmd_valid = 1'b0;
    frame();
    frame();
    frame();
    chk("mid.x0", {6'd0, display_x0}, 16'd208);
    rst_n = 1'b0;
    tick();
    chk_rect("mid.rst", 220, 240, 420, 400);
    chk("mid.busy", {15'd0, busy}, 16'd0);
    chk("mid.ready", {15'd0, cmd_ready}, 16'd1);
    rst_n = 1'b1;
    frame();
    chk_rect("mid.post", 220, 240, 420, 400);
    chk("mid.done", {15'd0, done}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
